// File: rtl/touch_pkg.sv
// rtl/touch_pkg.sv - shared constants for the touch-key pin protocol
//
// Purpose: FSM state encodings, the idle pin level and the default tap timing.
// The receiver side imports the same KEY_IDLE level, so both ends agree on polarity.
// Ports: none (package).

package touch_pkg;

    typedef logic [1:0] tap_state_t;

    localparam tap_state_t ST_IDLE  = 2'd0;
    localparam tap_state_t ST_PRESS = 2'd1;
    localparam tap_state_t ST_GAP   = 2'd2;

    // Pin is released high; a press pulls it low.
    localparam logic KEY_IDLE = 1'b1;

    // 10 ms phases at a 50 MHz system clock.
    localparam int DEF_PRESS_CYC = 500_000;
    localparam int DEF_GAP_CYC   = 500_000;

endpackage

// File: rtl/touch_tap_gen_phase_timer.sv
// rtl/touch_tap_gen_phase_timer.sv - loadable down-counter timing one PRESS/GAP phase
//
// Purpose: loaded with PHASE_CYC-1 at the start of a phase, it counts down
// while enabled and stops at zero. tc_o flags the last cycle of the phase.
// Ports:
//   clk_i       in   1      clock
//   rst_ni      in   1      asynchronous active-low reset
//   load_i      in   1      load load_val_i (takes priority over en_i)
//   load_val_i  in   CNT_W  value to load
//   en_i        in   1      count down by one when not already zero
//   tc_o        out  1      counter is at zero (terminal count)

module phase_timer #(
    parameter int CNT_W = 20
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             en_i,
    output logic             tc_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Holds at zero rather than wrapping, so a stalled FSM never sees a
    // spurious second terminal count.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/touch_tap_gen.sv
// rtl/touch_tap_gen.sv - emits N active-low taps on a touch-key pin per start command
//
// Purpose: an accepted start produces tap_num pulses, each PRESS_CYC cycles low
// followed by GAP_CYC cycles high, then a one-cycle done pulse.
// Ports:
//   sys_clk    in   1      system clock
//   sys_rst_n  in   1      asynchronous active-low reset
//   start      in   1      command strobe, only looked at while busy==0
//   tap_num    in   TAP_W  number of taps, latched with an accepted start
//   abort      in   1      cancel current command, return to idle without done
//   key_out    out  1      tap waveform, idle high, registered
//   busy       out  1      command in progress, registered
//   done       out  1      one-cycle pulse on normal completion, registered

module touch_tap_gen
    import touch_pkg::*;
#(
    parameter int PRESS_CYC = DEF_PRESS_CYC,
    parameter int GAP_CYC   = DEF_GAP_CYC,
    parameter int CNT_W     = 20,
    parameter int TAP_W     = 4
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             start,
    input  logic [TAP_W-1:0] tap_num,
    input  logic             abort,
    output logic             key_out,
    output logic             busy,
    output logic             done
);

    localparam logic [CNT_W-1:0] PRESS_LD = CNT_W'(PRESS_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_CYC - 1);

    tap_state_t       state_q;
    tap_state_t       state_d;
    logic [TAP_W-1:0] tap_q;
    logic [TAP_W-1:0] tap_d;
    logic             key_out_q;
    logic             key_out_d;
    logic             busy_q;
    logic             busy_d;
    logic             done_q;
    logic             done_d;

    logic             tmr_load;
    logic [CNT_W-1:0] tmr_load_val;
    logic             tmr_en;
    logic             tmr_tc;

    logic             accept;
    logic             gap_end;
    logic             last_tap;

    phase_timer #(
        .CNT_W (CNT_W)
    ) u_phase_timer (
        .clk_i      (sys_clk),
        .rst_ni     (sys_rst_n),
        .load_i     (tmr_load),
        .load_val_i (tmr_load_val),
        .en_i       (tmr_en),
        .tc_o       (tmr_tc)
    );

    // A zero-tap command is dropped entirely; abort in the same cycle also drops it.
    assign accept   = (state_q == ST_IDLE) && start && (tap_num != '0) && !abort;
    assign gap_end  = (state_q == ST_GAP) && tmr_tc;
    assign last_tap = (tap_q <= TAP_W'(1));

    // State register, together with the registered outputs derived from next state.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q   <= ST_IDLE;
            tap_q     <= '0;
            key_out_q <= KEY_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tap_q     <= tap_d;
            key_out_q <= key_out_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Next-state, tap counter and phase timer control.
    always_comb begin
        state_d      = state_q;
        tap_d        = tap_q;
        tmr_load     = 1'b0;
        tmr_load_val = '0;
        tmr_en       = 1'b0;

        if (abort) begin
            state_d  = ST_IDLE;
            tap_d    = '0;
            tmr_load = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        state_d      = ST_PRESS;
                        tap_d        = tap_num;
                        tmr_load     = 1'b1;
                        tmr_load_val = PRESS_LD;
                    end
                end
                ST_PRESS: begin
                    tmr_en = 1'b1;
                    if (tmr_tc) begin
                        state_d      = ST_GAP;
                        tmr_load     = 1'b1;
                        tmr_load_val = GAP_LD;
                    end
                end
                ST_GAP: begin
                    tmr_en = 1'b1;
                    if (tmr_tc) begin
                        // Tap count only moves here, and stops at zero.
                        if (last_tap) begin
                            state_d = ST_IDLE;
                            tap_d   = '0;
                        end else begin
                            state_d      = ST_PRESS;
                            tap_d        = tap_q - 1'b1;
                            tmr_load     = 1'b1;
                            tmr_load_val = PRESS_LD;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    tap_d   = '0;
                end
            endcase
        end
    end

    // Outputs are computed from the next state so that the registered pin
    // changes in the same cycle the FSM enters a phase.
    always_comb begin
        key_out_d = (state_d == ST_PRESS) ? ~KEY_IDLE : KEY_IDLE;
        busy_d    = (state_d != ST_IDLE);
        done_d    = gap_end && last_tap && !abort;
    end

    assign key_out = key_out_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_touch_tap_gen.sv
// tb/tb_touch_tap_gen.sv - directed self-checking bench for touch_tap_gen

module tb_touch_tap_gen;

    localparam int PRESS = 4;
    localparam int GAP   = 3;
    localparam int TAP   = PRESS + GAP;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] tap_num;
    logic       abort;
    logic       key_out;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_errors = 0;

    // Receiver model state: falling edges seen, LED toggled on each one.
    logic prev_key = 1'b1;
    logic led      = 1'b0;
    int   falls    = 0;
    int   led_tog  = 0;
    int   hi_run   = 0;
    int   last_gap = 0;

    touch_tap_gen #(
        .PRESS_CYC (PRESS),
        .GAP_CYC   (GAP),
        .CNT_W     (3),
        .TAP_W     (4)
    ) dut (
        .sys_clk   (clk),
        .sys_rst_n (rst_n),
        .start     (start),
        .tap_num   (tap_num),
        .abort     (abort),
        .key_out   (key_out),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic sample();
        if (prev_key === 1'b1 && key_out === 1'b0) begin
            falls++;
            led = ~led;
            led_tog++;
            last_gap = hi_run;
        end
        hi_run   = (key_out === 1'b1) ? hi_run + 1 : 0;
        prev_key = key_out;
    endtask

    // One clock edge, then settle on the falling edge and feed the receiver model.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        sample();
    endtask

    // Issue an n-tap command at the current negedge and check every cycle up to
    // and including the done cycle. dup_k>0 re-pulses start in that cycle.
    task automatic run_cmd(input int n, input int dup_k, input bit chk_gap, input string tag);
        int tot;
        int f0;
        int t0;
        int p;
        logic ek;
        tot = n * TAP;
        f0  = falls;
        t0  = led_tog;
        start   = 1'b1;
        tap_num = 4'(n);
        tick();
        start   = 1'b0;
        tap_num = 4'd9;
        for (int k = 1; k <= tot + 1; k++) begin
            p  = (k - 1) % TAP;
            ek = (k <= tot && p < PRESS) ? 1'b0 : 1'b1;
            chk($sformatf("%s key k=%0d", tag, k), 32'(key_out), 32'(ek));
            chk($sformatf("%s busy k=%0d", tag, k), 32'(busy), 32'(k <= tot));
            chk($sformatf("%s done k=%0d", tag, k), 32'(done), 32'(k == tot + 1));
            if (k == 1 && chk_gap)
                chk($sformatf("%s gap>=3", tag), 32'(last_gap >= GAP), 32'd1);
            if (k == dup_k) begin
                start   = 1'b1;
                tap_num = 4'd5;
            end else begin
                start = 1'b0;
            end
            if (k <= tot) tick();
        end
        chk($sformatf("%s falls", tag), 32'(falls - f0), 32'(n));
        chk($sformatf("%s led toggles", tag), 32'(led_tog - t0), 32'(n));
    endtask

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        tap_num = 4'd0;
        abort   = 1'b0;
        tick();
        tick();
        chk("reset key", 32'(key_out), 32'd1);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        rst_n = 1'b1;
        tick();
        tick();

        // Single tap, then three taps.
        run_cmd(1, 0, 1'b0, "one");
        tick();
        run_cmd(3, 0, 1'b0, "three");
        chk("led after 3 taps", 32'(led), 32'd0);
        tick();

        // Zero-tap start is ignored.
        start   = 1'b1;
        tap_num = 4'd0;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("zero busy i=%0d", i), 32'(busy), 32'd0);
            chk($sformatf("zero done i=%0d", i), 32'(done), 32'd0);
            chk($sformatf("zero key i=%0d", i), 32'(key_out), 32'd1);
            tick();
        end

        // Second start while busy is ignored; only one done.
        run_cmd(2, 3, 1'b0, "dup");
        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("dup after busy i=%0d", i), 32'(busy), 32'd0);
            chk($sformatf("dup after done i=%0d", i), 32'(done), 32'd0);
        end

        // Abort at t+2 of a 2-tap command.
        start   = 1'b1;
        tap_num = 4'd2;
        tick();
        start = 1'b0;
        tick();
        chk("abort pre key", 32'(key_out), 32'd0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort key", 32'(key_out), 32'd1);
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort done", 32'(done), 32'd0);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk($sformatf("abort no done i=%0d", i), 32'(done), 32'd0);
            chk($sformatf("abort idle key i=%0d", i), 32'(key_out), 32'd1);
        end

        // Abort and start together in idle: start dropped.
        start   = 1'b1;
        abort   = 1'b1;
        tap_num = 4'd2;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("abort+start busy", 32'(busy), 32'd0);
        chk("abort+start key", 32'(key_out), 32'd1);
        tick();
        chk("abort+start busy2", 32'(busy), 32'd0);

        // Asynchronous reset in the middle of a press.
        start   = 1'b1;
        tap_num = 4'd1;
        tick();
        start = 1'b0;
        tick();
        chk("pre-reset key", 32'(key_out), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("async reset key", 32'(key_out), 32'd1);
        chk("async reset busy", 32'(busy), 32'd0);
        chk("async reset done", 32'(done), 32'd0);
        tick();
        tick();
        chk("held reset key", 32'(key_out), 32'd1);
        rst_n = 1'b1;
        tick();
        chk("post reset busy", 32'(busy), 32'd0);
        run_cmd(1, 0, 1'b0, "after_rst");

        // Back-to-back: start in the done cycle.
        tick();
        run_cmd(1, 0, 1'b0, "b2b_a");
        run_cmd(2, 0, 1'b1, "b2b_b");

        tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
